// File: rtl/adder_defs.sv
// Shared definitions for the bit-serial adder family: FSM state encoding,
// default datapath width and counter sizing helper.
package adder_defs;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit counter width: clog2(width), never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder composed of two cascaded half adders and a carry OR.
module full_adder (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  logic s0;
  logic c0;
  logic c1;

  half_adder u_ha0 (
    .x(x),
    .y(y),
    .s(s0),
    .c(c0)
  );

  half_adder u_ha1 (
    .x(s0),
    .y(ci),
    .s(s),
    .c(c1)
  );

  assign co = c0 | c1;

endmodule

// File: rtl/half_adder.sv
// Single-bit half adder: sum and carry of two input bits.
module half_adder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);

  assign s = x ^ y;
  assign c = x & y;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial two's-complement adder, LSB first, one bit per clock, with a
// start/busy/done handshake and registered sum/carry-out/overflow results.
module serial_adder
  import adder_defs::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned    CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sha_q, sha_d;
  logic [WIDTH-1:0] shb_q, shb_d;
  logic [WIDTH-2:0] shs_q, shs_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             fa_s;
  logic             fa_c;

  full_adder u_fa (
    .x (sha_q[0]),
    .y (shb_q[0]),
    .ci(carry_q),
    .s (fa_s),
    .co(fa_c)
  );

  always_comb begin
    state_d = state_q;
    sha_d   = sha_q;
    shb_d   = shb_q;
    shs_d   = shs_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          sha_d   = a;
          shb_d   = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end

      RUN: begin
        sha_d   = sha_q >> 1;
        shb_d   = shb_q >> 1;
        // The partial-sum register is one bit short of WIDTH: the final bit
        // goes straight into the result, so nothing is ever shifted out unused.
        shs_d   = (WIDTH - 1)'({fa_s, shs_q} >> 1);
        carry_d = fa_c;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          sum_d   = {fa_s, shs_q};
          cout_d  = fa_c;
          ovf_d   = carry_q ^ fa_c;
          cnt_d   = '0;
          state_d = DONE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sha_q   <= '0;
      shb_q   <= '0;
      shs_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sha_q   <= sha_d;
      shb_q   <= shb_d;
      shs_q   <= shs_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder at WIDTH=8 and WIDTH=5: stimulus pushes
// reference results, per-instance monitors pop and compare on done.
module tb_serial_adder;

  typedef struct packed {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic       cin8 = 1'b0;
  logic       busy8, done8, cout8, ovf8;
  logic [7:0] sum8;

  logic       start5 = 1'b0;
  logic [4:0] a5 = '0;
  logic [4:0] b5 = '0;
  logic       cin5 = 1'b0;
  logic       busy5, done5, cout5, ovf5;
  logic [4:0] sum5;

  int   checks = 0;
  int   errors = 0;
  exp_t q8[$];
  exp_t q5[$];

  logic [7:0] last_sum8 = '0;
  logic       last_c8 = 1'b0;
  logic       last_o8 = 1'b0;
  logic [4:0] last_sum5 = '0;
  logic       last_c5 = 1'b0;
  logic       last_o5 = 1'b0;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  serial_adder #(.WIDTH(5)) dut5 (
    .clk(clk), .rst(rst), .start(start5), .a(a5), .b(b5), .cin(cin5),
    .busy(busy5), .done(done5), .sum(sum5), .cout(cout5), .ovf(ovf5)
  );

  always #5 clk = ~clk;

  // Reference: integer arithmetic on unsigned and signed interpretations.
  function automatic exp_t ref_add(input int w, input int av, input int bv, input int cv);
    exp_t r;
    int   m, total, sa, sb, ss;
    m     = 1 << w;
    total = av + bv + cv;
    sa    = (av >= m / 2) ? av - m : av;
    sb    = (bv >= m / 2) ? bv - m : bv;
    ss    = sa + sb + cv;
    r.sum  = 8'(total % m);
    r.cout = (total >= m);
    r.ovf  = (ss > m / 2 - 1) || (ss < -(m / 2));
    return r;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      last_sum8 = '0; last_c8 = 1'b0; last_o8 = 1'b0;
    end else if (done8) begin
      if (q8.size() == 0) begin
        checks++; errors++;
        $display("FAIL done8_unexpected: got done=1 expected no pending op at %0t", $time);
      end else begin
        exp_t e;
        e = q8.pop_front();
        check("sum8", 32'(sum8), 32'(e.sum));
        check("cout8", 32'(cout8), 32'(e.cout));
        check("ovf8", 32'(ovf8), 32'(e.ovf));
        last_sum8 = e.sum; last_c8 = e.cout; last_o8 = e.ovf;
      end
    end else begin
      check("hold8", 32'({cout8, ovf8, sum8}), 32'({last_c8, last_o8, last_sum8}));
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      last_sum5 = '0; last_c5 = 1'b0; last_o5 = 1'b0;
    end else if (done5) begin
      if (q5.size() == 0) begin
        checks++; errors++;
        $display("FAIL done5_unexpected: got done=1 expected no pending op at %0t", $time);
      end else begin
        exp_t e;
        e = q5.pop_front();
        check("sum5", 32'(sum5), 32'(e.sum[4:0]));
        check("cout5", 32'(cout5), 32'(e.cout));
        check("ovf5", 32'(ovf5), 32'(e.ovf));
        last_sum5 = e.sum[4:0]; last_c5 = e.cout; last_o5 = e.ovf;
      end
    end else begin
      check("hold5", 32'({cout5, ovf5, sum5}), 32'({last_c5, last_o5, last_sum5}));
    end
  end

  // Issue at a negedge; returns at the negedge where done is seen.
  task automatic run_op8(input int ai, input int bi, input int ci);
    int n;
    a8 = 8'(ai); b8 = 8'(bi); cin8 = 1'(ci); start8 = 1'b1;
    q8.push_back(ref_add(8, ai, bi, ci));
    @(posedge clk);
    #1 start8 = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!done8 && n < 9) check("busy8_run", 32'(busy8), 1);
    end while (!done8 && n < 20);
    check("latency8", n, 9);
  endtask

  task automatic run_op5(input int ai, input int bi, input int ci);
    int n;
    a5 = 5'(ai); b5 = 5'(bi); cin5 = 1'(ci); start5 = 1'b1;
    q5.push_back(ref_add(5, ai, bi, ci));
    @(posedge clk);
    #1 start5 = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done5 && n < 20);
    check("latency5", n, 6);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy8", 32'(busy8), 0);
    check("rst_done8", 32'(done8), 0);
    check("rst_out8", 32'({cout8, ovf8, sum8}), 0);
    check("rst_out5", 32'({busy5, done5, cout5, ovf5, sum5}), 0);
    #2 rst = 1'b0;
    @(negedge clk);

    run_op8('h5A, 'h3C, 0);
    @(negedge clk);
    run_op8('hFF, 'h01, 0);
    run_op8('h7F, 'h00, 1);
    run_op8('h80, 'h80, 0);
    @(negedge clk);

    // Start held high; operands scrambled during RUN must not be resampled.
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b1; start8 = 1'b1;
    q8.push_back(ref_add(8, 'h12, 'h34, 1));
    @(posedge clk);
    #1;
    for (int n = 1; n <= 9; n++) begin
      @(negedge clk);
      if (n < 9) begin
        check("b2b_busy1", 32'(busy8), 1);
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      end else begin
        check("b2b_done1", 32'(done8), 1);
        check("b2b_idle1", 32'(busy8), 0);
        a8 = 8'hC3; b8 = 8'h4E; cin8 = 1'b0;
        q8.push_back(ref_add(8, 'hC3, 'h4E, 0));
      end
    end
    for (int n = 1; n <= 9; n++) begin
      @(negedge clk);
      if (n < 9) begin
        check("b2b_busy2", 32'(busy8), 1);
      end else begin
        check("b2b_done2", 32'(done8), 1);
        start8 = 1'b0;
      end
    end
    @(negedge clk);
    check("b2b_end_busy", 32'(busy8), 0);

    // Asynchronous reset in the middle of an operation.
    a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", 32'(busy8), 0);
    check("arst_done", 32'(done8), 0);
    check("arst_out", 32'({cout8, ovf8, sum8}), 0);
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (12) @(negedge clk);
    check("arst_idle", 32'(busy8), 0);
    run_op8('h01, 'h02, 0);
    @(negedge clk);

    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          run_op8(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                  int'($urandom_range(0, 1)));
          repeat ($urandom_range(0, 2)) @(negedge clk);
        end
      end
      begin
        for (int i = 0; i < 1000; i++) begin
          run_op5(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                  int'($urandom_range(0, 1)));
          repeat ($urandom_range(0, 2)) @(negedge clk);
        end
      end
    join

    repeat (3) @(negedge clk);
    check("drain8", q8.size(), 0);
    check("drain5", q5.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
